uart_tx_fifo: RTL and testbench

//   Byte FIFO sitting directly upstream of the uart transmitter. Producers push

---
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer/uart-side signal bundle for uart_tx_fifo.
// The slave modport is the FIFO's view; master is the producer plus the uart.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      wr_data;
    logic            wr_en;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] level;
    logic            overflow;
    logic [7:0]      tx_byte;
    logic            send_request;
    logic            busy;

    modport slave (
        input  wr_data, wr_en, busy,
        output full, empty, level, overflow, tx_byte, send_request
    );

    modport master (
        output wr_data, wr_en, busy,
        input  full, empty, level, overflow, tx_byte, send_request
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the uart transmitter: buffers producer writes and feeds
// the uart one byte per send_request/busy handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a queued byte and busy low; pops and requests
// WAIT_HI | request issued, waiting for busy to rise (bounded by timeout)
// WAIT_LO | uart transmitting, waiting for busy to fall
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_fifo_if.slave bus
);
    localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WAIT_LO = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              send_req_q, send_req_d;
    logic              overflow_q, overflow_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic full, empty, push, pop;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    // full is the registered value, so a pop on the same edge never frees room
    assign push  = bus.wr_en && !full;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        tx_byte_d  = tx_byte_q;
        send_req_d = 1'b0;
        timer_d    = timer_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !bus.busy) begin
                    pop        = 1'b1;
                    tx_byte_d  = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                    send_req_d = 1'b1;
                    timer_d    = '0;
                    state_d    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (bus.busy) begin
                    state_d = S_WAIT_LO;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!bus.busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = bus.wr_en && full;
        if (push) begin
            mem_d[wr_ptr_q] = bus.wr_data;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tx_byte_q  <= '0;
            send_req_q <= 1'b0;
            overflow_q <= 1'b0;
            timer_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tx_byte_q  <= tx_byte_d;
            send_req_q <= send_req_d;
            overflow_q <= overflow_d;
            timer_q    <= timer_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.tx_byte      = tx_byte_q;
    assign bus.send_request = send_req_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo with a queue-based reference model
// and a simple uart busy model (busy rises one cycle after a request, 10-cycle frame).
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.ADDR_W(4)) bif();

    logic uart_busy = 1'b0;
    logic hold_busy = 1'b0;
    assign bif.busy = uart_busy | hold_busy;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .BUSY_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] exp_q[$];
    int acc = 0;
    int pops = 0;
    bit busy_mode = 1'b1;
    bit rise_pending = 1'b0;
    int frame_left = 0;
    int cyc = 0;
    int last_req = -1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // uart model: acts 1 time unit after each rising edge
    always begin
        logic busy_at_edge;
        @(posedge clk);
        #1;
        cyc++;
        busy_at_edge = bif.busy;
        if (rise_pending) begin
            uart_busy    = 1'b1;
            frame_left   = 10;
            rise_pending = 1'b0;
        end else if (frame_left > 0) begin
            frame_left--;
            if (frame_left == 0) uart_busy = 1'b0;
        end
        if (bif.send_request === 1'b1) begin
            pops++;
            check("req_while_busy", busy_at_edge, 0);
            check("tx_queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("tx_byte", bif.tx_byte, exp_q.pop_front());
            if (!busy_mode) begin
                if (last_req >= 0)
                    check("timeout_gap", (cyc - last_req >= 16) && (cyc - last_req <= 17), 1);
                last_req = cyc;
            end else begin
                rise_pending = 1'b1;
            end
        end
    end

    task automatic step(bit we, logic [7:0] d);
        int lvl_before;
        bit drop;
        bif.wr_en   = we;
        bif.wr_data = d;
        lvl_before  = acc - pops;
        @(posedge clk);
        drop = we && (lvl_before == DEPTH);
        if (we && !drop) begin
            exp_q.push_back(d);
            acc++;
        end
        @(negedge clk);
        bif.wr_en = 1'b0;
        check("level",    bif.level, acc - pops);
        check("full",     bif.full, (acc - pops) == DEPTH);
        check("empty",    bif.empty, (acc - pops) == 0);
        check("overflow", bif.overflow, drop);
    endtask

    task automatic drain(int max_steps);
        int n = 0;
        int quiet = 0;
        while (quiet < 25 && n < max_steps) begin
            step(1'b0, 8'h00);
            n++;
            if (acc == pops && !uart_busy && !rise_pending) quiet++;
            else quiet = 0;
        end
        check("drain_done", quiet >= 25, 1);
    endtask

    initial begin
        int n;
        bit we;
        rst = 1'b1;
        bif.wr_en = 1'b0;
        bif.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_level", bif.level, 0);
        check("rst_empty", bif.empty, 1);
        check("rst_full", bif.full, 0);
        check("rst_overflow", bif.overflow, 0);
        check("rst_send_request", bif.send_request, 0);
        check("rst_tx_byte", bif.tx_byte, 0);
        rst = 1'b0;

        // single byte
        step(1'b1, 8'h61);
        drain(200);
        check("t1_requests", pops, 1);

        // fill to full with uart held busy, then overflow attempt
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h41 + i));
        check("t2_full", bif.full, 1);
        check("t2_level16", bif.level, 16);
        step(1'b1, 8'hEE);
        check("t3_level_after_ovf", bif.level, 16);
        step(1'b0, 8'h00);
        hold_busy = 1'b0;
        drain(600);
        check("t2_requests", pops, 17);

        // uart never raises busy: timeout path must not hang
        busy_mode = 1'b0;
        last_req  = -1;
        step(1'b1, 8'hA1);
        step(1'b1, 8'hA2);
        step(1'b1, 8'hA3);
        drain(300);
        check("t4_requests", pops, 20);
        busy_mode = 1'b1;

        // reset while in WAIT_LO with 5 bytes queued
        hold_busy = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i));
        hold_busy = 1'b0;
        n = 0;
        while (!uart_busy && n < 50) begin
            step(1'b0, 8'h00);
            n++;
        end
        check("t5_busy_seen", uart_busy, 1);
        step(1'b0, 8'h00);
        check("t5_level5", bif.level, 5);
        rst = 1'b1;
        exp_q.delete();
        acc = 0;
        pops = 0;
        @(negedge clk);
        check("t5_level0", bif.level, 0);
        check("t5_empty", bif.empty, 1);
        check("t5_send_request", bif.send_request, 0);
        check("t5_full", bif.full, 0);
        rst = 1'b0;
        step(1'b1, 8'h33);
        drain(300);
        check("t5_requests", pops, 1);

        // random stream across pointer wrap, level held near 8
        for (int i = 0; i < 700; i++) begin
            we = ((acc - pops) < 8) ? 1'b1 : ($urandom_range(0, 15) == 0);
            step(we, 8'($urandom_range(0, 255)));
        end
        drain(800);
        check("t6_all_sent", pops, acc);
        check("t6_enough_traffic", acc > 40, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
